// File: rtl/console_text_engine.sv
`timescale 1ns/1ps
// console_text_engine
// Text console for the bash I/O path: ROWS x COLS character grid, a line-edit
// buffer with left/right cursor movement, outbound line streaming and
// inbound response printing. Scrolling moves a circular top-row pointer and
// clears a single row, so the grid is never copied.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   key_valid, key_code        edge-detected key pulse and ASCII code
//   rd_row, rd_col             display read address (screen-relative row)
//   rd_char, rd_prompt         read data, one cycle after the address
//   cur_row, cur_col           cursor position
//   busy                       high whenever not editing
//   line_valid/ready/data/last outbound line stream
//   host_valid/data/ready      inbound response bytes
//   host_done                  response-finished pulse
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | blank every cell, one per cycle, then show the first prompt
// EDIT  | accept keys into the edit line
// SEND  | stream the edit line to the command processor
// HOST  | print response bytes; service a pending host_done
// CLEAR | blank the freshly scrolled-in bottom row, then back to HOST
module console_text_engine #(
  parameter int COLS       = 70,
  parameter int ROWS       = 30,
  parameter int PROMPT_LEN = 9,
  parameter int LINE_MAX   = 32,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int LW = $clog2(LINE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  input  logic [7:0]    key_code,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [7:0]    rd_char,
  output logic          rd_prompt,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic          busy,
  output logic          line_valid,
  input  logic          line_ready,
  output logic [7:0]    line_data,
  output logic          line_last,
  input  logic          host_valid,
  input  logic [7:0]    host_data,
  output logic          host_ready,
  input  logic          host_done
);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int BW    = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  localparam logic [AW-1:0] COLS_A     = AW'(COLS);
  localparam logic [AW-1:0] LAST_CELL  = AW'(CELLS - 1);
  localparam logic [AW-1:0] LAST_COL_A = AW'(COLS - 1);
  localparam logic [CW-1:0] PROMPT_C   = CW'(PROMPT_LEN);
  localparam logic [CW-1:0] LAST_COL_C = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [RW:0]   ROWS_S     = (RW+1)'(ROWS);
  localparam logic [LW-1:0] LINE_MAX_L = LW'(LINE_MAX);

  localparam logic [7:0] K_BS    = 8'h08;
  localparam logic [7:0] K_ENTER = 8'h0D;
  localparam logic [7:0] K_LEFT  = 8'h11;
  localparam logic [7:0] K_RIGHT = 8'h12;
  localparam logic [7:0] K_NL    = 8'h0A;
  localparam logic [7:0] SPACE   = 8'h20;

  typedef enum logic [2:0] {S_INIT, S_EDIT, S_SEND, S_HOST, S_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   top_q, top_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   pos_q, pos_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [ROWS-1:0] prompt_q, prompt_d;
  logic [7:0]      rd_char_q;
  logic            rd_prompt_q;

  logic [7:0]      mem_q [CELLS];
  logic [7:0]      buf_q [LINE_MAX];

  logic            mem_we, buf_we, nl;
  logic [AW-1:0]   mem_waddr;
  logic [7:0]      mem_wdata;

  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] t, input logic [RW-1:0] r);
    logic [RW:0] sum;
    sum = {1'b0, t} + {1'b0, r};
    if (sum >= ROWS_S) sum = sum - ROWS_S;
    return sum[RW-1:0];
  endfunction

  function automatic logic is_print(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  logic [RW-1:0] cur_phys, rd_phys;
  logic [AW-1:0] row_base, cur_addr, rd_addr;
  logic          at_end, send_last;
  logic [7:0]    send_byte;

  assign cur_phys  = phys_row(top_q, row_q);
  assign row_base  = AW'(cur_phys) * COLS_A;
  assign cur_addr  = row_base + AW'(col_q);
  assign rd_phys   = phys_row(top_q, rd_row);
  assign rd_addr   = AW'(rd_phys) * COLS_A + AW'(rd_col);
  assign at_end    = (pos_q == len_q);
  assign send_byte = buf_q[BW'(idx_q)];
  // An empty line still goes out as a single terminating beat.
  assign send_last = (len_q == '0) || (idx_q == len_q - LW'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    top_d     = top_q;
    row_d     = row_q;
    col_d     = col_q;
    len_d     = len_q;
    pos_d     = pos_q;
    idx_d     = idx_q;
    pend_d    = pend_q | host_done;
    prompt_d  = prompt_q;
    mem_we    = 1'b0;
    mem_waddr = cur_addr;
    mem_wdata = SPACE;
    buf_we    = 1'b0;
    nl        = 1'b0;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        if (cnt_q == '0) begin
          state_d     = S_EDIT;
          top_d       = '0;
          row_d       = '0;
          col_d       = PROMPT_C;
          prompt_d    = '0;
          prompt_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q - AW'(1);
        end
      end
      S_EDIT: begin
        if (key_valid) begin
          if (is_print(key_code)) begin
            if (!(at_end && len_q == LINE_MAX_L)) begin
              mem_we    = 1'b1;
              mem_wdata = key_code;
              buf_we    = 1'b1;
              if (at_end) len_d = len_q + LW'(1);
              pos_d = pos_q + LW'(1);
              col_d = col_q + CW'(1);
            end
          end else if (key_code == K_BS) begin
            if (at_end && len_q != '0) begin
              len_d     = len_q - LW'(1);
              pos_d     = pos_q - LW'(1);
              col_d     = col_q - CW'(1);
              mem_we    = 1'b1;
              mem_waddr = cur_addr - AW'(1);
            end
          end else if (key_code == K_LEFT) begin
            if (pos_q != '0) begin
              pos_d = pos_q - LW'(1);
              col_d = col_q - CW'(1);
            end
          end else if (key_code == K_RIGHT) begin
            if (pos_q < len_q) begin
              pos_d = pos_q + LW'(1);
              col_d = col_q + CW'(1);
            end
          end else if (key_code == K_ENTER) begin
            state_d = S_SEND;
            idx_d   = '0;
          end
        end
      end
      S_SEND: begin
        if (line_ready) begin
          if (send_last) begin
            nl      = 1'b1;
            len_d   = '0;
            pos_d   = '0;
            state_d = S_HOST;
          end else begin
            idx_d = idx_q + LW'(1);
          end
        end
      end
      S_HOST: begin
        if (host_valid) begin
          if (is_print(host_data)) begin
            mem_we    = 1'b1;
            mem_wdata = host_data;
            if (col_q == LAST_COL_C) nl = 1'b1;
            else                     col_d = col_q + CW'(1);
          end else if (host_data == K_NL) begin
            nl = 1'b1;
          end
        end else if (pend_q) begin
          // Two-step service: first get to column 0, then drop the prompt.
          if (col_q != '0) begin
            nl = 1'b1;
          end else begin
            prompt_d[cur_phys] = 1'b1;
            col_d              = PROMPT_C;
            pend_d             = host_done;
            state_d            = S_EDIT;
          end
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = row_base + cnt_q;
        if (cnt_q == '0) state_d = S_HOST;
        else             cnt_d   = cnt_q - AW'(1);
      end
      default: state_d = S_INIT;
    endcase
    if (nl) begin
      col_d = '0;
      if (row_q != LAST_ROW) begin
        row_d = row_q + RW'(1);
      end else begin
        // The old top physical row becomes the new bottom row.
        top_d           = (top_q == LAST_ROW) ? '0 : top_q + RW'(1);
        prompt_d[top_q] = 1'b0;
        state_d         = S_CLEAR;
        cnt_d           = LAST_COL_A;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= LAST_CELL;
      top_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      len_q       <= '0;
      pos_q       <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      prompt_q    <= '0;
      rd_char_q   <= 8'h00;
      rd_prompt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      top_q       <= top_d;
      row_q       <= row_d;
      col_q       <= col_d;
      len_q       <= len_d;
      pos_q       <= pos_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      prompt_q    <= prompt_d;
      rd_char_q   <= mem_q[rd_addr];
      rd_prompt_q <= prompt_q[rd_phys] & (rd_col < PROMPT_C);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (buf_we) buf_q[BW'(pos_q)] <= key_code;
  end

  assign rd_char    = rd_char_q;
  assign rd_prompt  = rd_prompt_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign busy       = (state_q != S_EDIT);
  assign line_valid = (state_q == S_SEND);
  assign line_data  = (state_q == S_SEND && len_q != '0) ? send_byte : 8'h00;
  assign line_last  = (state_q == S_SEND) && send_last;
  assign host_ready = (state_q == S_HOST);
endmodule
